// File: rtl/spi_master.sv
// SPI bus master: one DATA_WIDTH-bit full-duplex transfer per accepted start,
// any CPOL/CPHA mode, sclk divided down from the single system clock.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic [2:0]            state_dbg
);
  localparam int N  = DATA_WIDTH;
  localparam int H  = CLK_DIV;
  localparam int EW = $clog2(2 * N) + 1;
  localparam int DW = $clog2(H) + 1;

  // SETUP runs one cycle longer than a half-period so edge 0 lands at T0+1+H.
  localparam logic [DW-1:0] DIV_SETUP = DW'(H);
  localparam logic [DW-1:0] DIV_LAST  = DW'(H - 1);
  localparam logic [DW-1:0] DIV_GAP   = DW'(H - 2);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [N-1:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic          cpol_q, cpol_d, cpha_q, cpha_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic          rx_valid_q, rx_valid_d, busy_q, busy_d;
  logic          tick, lead;

  function automatic logic first_bit(input logic [N-1:0] w);
    return MSB_FIRST ? w[N-1] : w[0];
  endfunction

  function automatic logic [N-1:0] shift_out(input logic [N-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] w, input logic b);
    return MSB_FIRST ? {w[N-2:0], b} : {b, w[N-1:1]};
  endfunction

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    tick       = 1'b0;
    lead       = ~edge_cnt_q[0];
    unique case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d    = S_SETUP;
          cpol_d     = cpol;
          cpha_d     = cpha;
          div_d      = '0;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          if (cpha) begin
            tx_sh_d = tx_data;
          end else begin
            mosi_d  = first_bit(tx_data);
            tx_sh_d = shift_out(tx_data);
          end
        end
      end
      S_SETUP, S_XFER: begin
        tick  = (state_q == S_SETUP) ? (div_q == DIV_SETUP) : (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EW'(1);
          state_d    = (edge_cnt_q == EDGE_LAST) ? S_HOLD : S_XFER;
          // Sample edge is leading for CPHA=0, trailing for CPHA=1; the other edge shifts.
          if (lead ^ cpha_q) begin
            rx_sh_d = shift_in(rx_sh_q, miso);
          end else if (edge_cnt_q != EDGE_LAST) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
        end
      end
      S_HOLD: begin
        sclk_d = cpol_q;
        div_d  = div_q + DW'(1);
        if (div_q == DIV_LAST) begin
          state_d    = S_GAP;
          div_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      S_GAP: begin
        // One IDLE cycle follows GAP, so the total deselect time is exactly H.
        div_d = div_q + DW'(1);
        if (div_q == DIV_GAP) begin
          state_d = S_IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an MSB-first and an LSB-first instance share
// a behavioural SPI slave; expected words and latencies are hand-computed.
module tb_spi_master;
  localparam int N = 8;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, cpol, cpha, sel_lsb;
  logic [N-1:0] tx_data;
  logic         miso = 1'b0;
  logic         start_a, start_b;
  logic         sclk_a, cs_n_a, mosi_a, rxv_a, busy_a;
  logic         sclk_b, cs_n_b, mosi_b, rxv_b, busy_b;
  logic [N-1:0] rx_a, rx_b;
  logic [2:0]   st_a, st_b;
  logic         sclk_w, cs_n_w, mosi_w, rxv_w, busy_w;
  logic [N-1:0] rx_w;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign start_a = start & ~sel_lsb;
  assign start_b = start & sel_lsb;
  assign sclk_w  = sel_lsb ? sclk_b : sclk_a;
  assign cs_n_w  = sel_lsb ? cs_n_b : cs_n_a;
  assign mosi_w  = sel_lsb ? mosi_b : mosi_a;
  assign rxv_w   = sel_lsb ? rxv_b  : rxv_a;
  assign busy_w  = sel_lsb ? busy_b : busy_a;
  assign rx_w    = sel_lsb ? rx_b   : rx_a;

  spi_master #(.DATA_WIDTH(N), .MSB_FIRST(1'b1), .CLK_DIV(H)) u_dut_msb (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .miso(miso), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .rx_data(rx_a),
    .rx_valid(rxv_a), .busy(busy_a), .state_dbg(st_a)
  );

  spi_master #(.DATA_WIDTH(N), .MSB_FIRST(1'b0), .CLK_DIV(H)) u_dut_lsb (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .miso(miso), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .rx_data(rx_b),
    .rx_valid(rxv_b), .busy(busy_b), .state_dbg(st_b)
  );

  // ---------------- slave model and bus monitor ----------------
  logic         m_cpol = 1'b0, m_cpha = 1'b0;
  logic [N-1:0] slave_tx = '0;
  logic [N-1:0] s_tx = '0, s_rx = '0;
  logic         s_first = 1'b0;
  int           s_edges = 0, s_nsamp = 0;
  int           cs_falls = 0, rxv_pulses = 0, hi_len = 0, last_hi_len = 0;
  logic         prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!cs_n_w && prev_cs) begin
      cs_falls++;
      last_hi_len = hi_len;
      s_edges = 0;
      s_nsamp = 0;
      s_rx = '0;
      s_tx = slave_tx;
      if (!m_cpha) begin
        miso = sel_lsb ? s_tx[0] : s_tx[N-1];
        s_tx = sel_lsb ? (s_tx >> 1) : (s_tx << 1);
      end
    end else if (!cs_n_w && (sclk_w != prev_sclk)) begin
      s_edges++;
      if ((sclk_w != m_cpol) ^ m_cpha) begin
        if (s_nsamp == 0) s_first = mosi_w;
        s_nsamp++;
        s_rx = sel_lsb ? {mosi_w, s_rx[N-1:1]} : {s_rx[N-2:0], mosi_w};
      end else begin
        miso = sel_lsb ? s_tx[0] : s_tx[N-1];
        s_tx = sel_lsb ? (s_tx >> 1) : (s_tx << 1);
      end
    end
    if (cs_n_w) hi_len++;
    else        hi_len = 0;
    if (rxv_w) rxv_pulses++;
    prev_cs   = cs_n_w;
    prev_sclk = sclk_w;
  end

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int w = 0;
    while (busy_w && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One transfer; inputs are scrambled after accept to prove they were latched.
  task automatic run_xfer(input string tag, input logic lsb, input logic pol, input logic pha,
                          input logic [N-1:0] tx, input logic [N-1:0] stx,
                          input int poke, output int lat);
    sel_lsb = lsb; cpol = pol; cpha = pha; m_cpol = pol; m_cpha = pha;
    tx_data = tx; slave_tx = stx;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tx_data = ~tx; cpol = ~pol; cpha = ~pha;
    lat = 0;
    while (rxv_w !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == poke) begin
        start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd69);
    check_eq({tag, "_cs_hi"}, 32'(cs_n_w), 32'd1);
    check_eq({tag, "_mosi0"}, 32'(mosi_w), 32'd0);
    cpol = pol; cpha = pha;
    wait_idle();
    check_eq({tag, "_sclk_idle"}, 32'(sclk_w), 32'(pol));
    check_eq({tag, "_busy0"}, 32'(busy_w), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base_f, base_p, n;
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; sel_lsb = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sclk", 32'(sclk_a), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n_a), 32'd1);
    check_eq("rst_mosi", 32'(mosi_a), 32'd0);
    check_eq("rst_rx", 32'(rx_a), 32'd0);
    check_eq("rst_rxv", 32'(rxv_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, A5 out / 3C back
    base_p = rxv_pulses;
    run_xfer("m0", 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, -1, lat);
    check_eq("m0_rx", 32'(rx_w), 32'h3C);
    check_eq("m0_slave_rx", 32'(s_rx), 32'hA5);
    check_eq("m0_edges", 32'(s_edges), 32'd16);
    check_eq("m0_pulses", 32'(rxv_pulses - base_p), 32'd1);

    // Modes 1, 2, 3
    for (int m = 1; m < 4; m++) begin
      run_xfer($sformatf("mode%0d", m), 1'b0, m[1], m[0], 8'h5A, 8'hC3, -1, lat);
      check_eq($sformatf("mode%0d_rx", m), 32'(rx_w), 32'hC3);
      check_eq($sformatf("mode%0d_slave_rx", m), 32'(s_rx), 32'h5A);
      check_eq($sformatf("mode%0d_edges", m), 32'(s_edges), 32'd16);
    end

    // LSB-first instance
    run_xfer("lsb", 1'b1, 1'b0, 1'b0, 8'h01, 8'h80, -1, lat);
    check_eq("lsb_rx", 32'(rx_w), 32'h80);
    check_eq("lsb_slave_rx", 32'(s_rx), 32'h01);
    check_eq("lsb_first_bit", 32'(s_first), 32'd1);

    // start during a transfer is ignored
    base_f = cs_falls; base_p = rxv_pulses;
    run_xfer("ign", 1'b0, 1'b0, 1'b0, 8'h96, 8'h69, 10, lat);
    repeat (3 * H) @(posedge clk);
    #1;
    check_eq("ign_rx", 32'(rx_w), 32'h69);
    check_eq("ign_cs_falls", 32'(cs_falls - base_f), 32'd1);
    check_eq("ign_pulses", 32'(rxv_pulses - base_p), 32'd1);

    // asynchronous reset mid-transfer
    sel_lsb = 1'b0; cpol = 1'b1; cpha = 1'b1; m_cpol = 1'b1; m_cpha = 1'b1;
    tx_data = 8'hF0; slave_tx = 8'h0F;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check_eq("rmid_busy_before", 32'(busy_w), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rmid_cs_n", 32'(cs_n_w), 32'd1);
    check_eq("rmid_sclk", 32'(sclk_w), 32'd0);
    check_eq("rmid_busy", 32'(busy_w), 32'd0);
    check_eq("rmid_rxv", 32'(rxv_w), 32'd0);
    check_eq("rmid_rx", 32'(rx_w), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_xfer("rpost", 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, -1, lat);
    check_eq("rpost_rx", 32'(rx_w), 32'h3C);
    check_eq("rpost_slave_rx", 32'(s_rx), 32'hA5);

    // start held high: back-to-back transfers
    sel_lsb = 1'b0; cpol = 1'b0; cpha = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
    tx_data = 8'h3C; slave_tx = 8'hA5;
    base_f = cs_falls;
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = 0; lat = 0;
    while (n < 2 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (rxv_w) n++;
    end
    start = 1'b0;
    check_eq("b2b_pulses", 32'(n), 32'd2);
    check_eq("b2b_rx", 32'(rx_w), 32'hA5);
    wait_idle();
    check_eq("b2b_gap", 32'(last_hi_len), 32'(H));
    check_eq("b2b_cs_falls", 32'(cs_falls - base_f), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
